// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin arbiter that shares one iterative shift/add-3
// binary-to-BCD converter among N_REQ 8-bit requesters.
// Optional seven-segment outputs are enabled with `define BCD_ARB_SEG_EN.
module bcd_conv_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*8-1:0] req_data,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               out_valid,
    output logic [ID_W-1:0]    out_id,
    output logic [3:0]         bcd_100,
    output logic [3:0]         bcd_10,
    output logic [3:0]         bcd_1
`ifdef BCD_ARB_SEG_EN
    ,
    output logic [6:0]         seg_100,
    output logic [6:0]         seg_10,
    output logic [6:0]         seg_1
`endif
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state;
    logic [19:0]      shreg;
    logic [19:0]      shreg_next;
    logic [2:0]       iter;
    logic [ID_W-1:0]  last_id;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  sel;
    logic             found;
    logic [7:0]       sel_data;

    // One double-dabble iteration: condition each BCD nibble, then shift left.
    function automatic logic [19:0] dabble(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[11:8]  > 4'd4) t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] > 4'd4) t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] > 4'd4) t[19:16] = t[19:16] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

`ifdef BCD_ARB_SEG_EN
    // abcdefg segment code, segment a in the MSB, active high.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction
`endif

    // Next shift-register value for the current conversion step.
    always_comb begin
        shreg_next = dabble(shreg);
    end

    // Round-robin pick: first active request after last_id, wrapping.
    // Scanning the offsets from the far end lets the nearest one win last.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        sel      = '0;
        found    = 1'b0;
        sel_data = '0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            idx = (32'(last_id) + k) % N_REQ;
            if (req[ID_W'(idx)]) begin
                sel      = ID_W'(idx);
                found    = 1'b1;
                sel_data = 8'(req_data >> (8 * idx));
            end
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            iter      <= '0;
            last_id   <= ID_W'(N_REQ - 1);
            cur_id    <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_id    <= '0;
            bcd_100   <= '0;
            bcd_10    <= '0;
            bcd_1     <= '0;
`ifdef BCD_ARB_SEG_EN
            seg_100   <= '0;
            seg_10    <= '0;
            seg_1     <= '0;
`endif
        end else begin
            grant     <= '0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        shreg   <= {12'b0, sel_data};
                        last_id <= sel;
                        cur_id  <= sel;
                        iter    <= '0;
                        grant   <= N_REQ'(1) << sel;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    shreg <= shreg_next;
                    iter  <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        bcd_100   <= shreg_next[19:16];
                        bcd_10    <= shreg_next[15:12];
                        bcd_1     <= shreg_next[11:8];
`ifdef BCD_ARB_SEG_EN
                        seg_100   <= seg7(shreg_next[19:16]);
                        seg_10    <= seg7(shreg_next[15:12]);
                        seg_1     <= seg7(shreg_next[11:8]);
`endif
                        out_id    <= cur_id;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
